multicycle_ctrl: RTL and testbench

- Multi-cycle main controller: a Moore FSM that sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB.
- Sits directly upstream of the CPU datapath. Consumes the datapath's op/func fields and drives every datapath control input.
- Adds PCWrite/IRWrite stage enables so the PC register and the instruction register update only in the correct stage.
- Replaces the single-cycle combinational decoder; the datapath mux encodings stay the same.

---
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: a Moore FSM that steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives every datapath control input, including PC/IR enables.
module multicycle_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegWriteCtr,
    output logic [1:0] RegSel,
    output logic       ALUSelA,
    output logic       ALUSelB,
    output logic [3:0] ALUCtr,
    output logic       MemWrite,
    output logic [1:0] MemWriteCtr,
    output logic [2:0] MemOutCtr,
    output logic [1:0] EXTCtr,
    output logic [2:0] nPCSel,
    output logic [2:0] State,
    output logic       InstrDone,
    output logic       Illegal
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } stateT;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_SLT, C_SLL, C_JR,
        C_ORI, C_ADDIU, C_LUI, C_LW, C_SW,
        C_BEQ, C_BNE, C_J, C_JAL, C_ILL
    } classT;

    stateT stateReg, stateNext;
    classT classReg, decClass;

    logic       pcWriteNext, irWriteNext, regWriteNext, memWriteNext, doneNext, illegalNext;
    logic       selActive;
    logic [1:0] regWriteCtrDec, regSelDec, extCtrDec;
    logic       aluSelADec, aluSelBDec;
    logic [3:0] aluCtrDec;
    logic [2:0] nPCSelDec;

    // Instruction classification; only meaningful while the IR is stable in DECODE.
    always_comb begin
        decClass = C_ILL;
        case (op)
            6'b000000: begin
                case (func)
                    6'b100001: decClass = C_ADDU;
                    6'b100011: decClass = C_SUBU;
                    6'b101010: decClass = C_SLT;
                    6'b000000: decClass = C_SLL;
                    6'b001000: decClass = C_JR;
                    default:   decClass = C_ILL;
                endcase
            end
            6'b001101: decClass = C_ORI;
            6'b001001: decClass = C_ADDIU;
            6'b001111: decClass = C_LUI;
            6'b100011: decClass = C_LW;
            6'b101011: decClass = C_SW;
            6'b000100: decClass = C_BEQ;
            6'b000101: decClass = C_BNE;
            6'b000010: decClass = C_J;
            6'b000011: decClass = C_JAL;
            default:   decClass = C_ILL;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateReg <= FETCH;
            classReg <= C_ILL;
        end else begin
            stateReg <= stateNext;
            if (stateReg == DECODE) begin
                classReg <= decClass;
            end
        end
    end

    always_comb begin
        stateNext    = stateReg;
        pcWriteNext  = 1'b0;
        irWriteNext  = 1'b0;
        regWriteNext = 1'b0;
        memWriteNext = 1'b0;
        doneNext     = 1'b0;
        illegalNext  = 1'b0;
        case (stateReg)
            FETCH: begin
                irWriteNext = 1'b1;
                stateNext   = DECODE;
            end
            DECODE: begin
                illegalNext = (decClass == C_ILL);
                stateNext   = (illegalNext && HALT_ON_ILLEGAL) ? HALT : EXEC;
            end
            EXEC: begin
                case (classReg)
                    C_BEQ, C_BNE, C_J, C_JR, C_ILL: begin
                        pcWriteNext = 1'b1;
                        doneNext    = 1'b1;
                        stateNext   = FETCH;
                    end
                    C_JAL: begin
                        pcWriteNext  = 1'b1;
                        regWriteNext = 1'b1;
                        doneNext     = 1'b1;
                        stateNext    = FETCH;
                    end
                    C_LW, C_SW: stateNext = MEM;
                    default:    stateNext = WB;
                endcase
            end
            MEM: begin
                if (classReg == C_SW) begin
                    memWriteNext = 1'b1;
                    pcWriteNext  = 1'b1;
                    doneNext     = 1'b1;
                    stateNext    = FETCH;
                end else begin
                    stateNext = WB;
                end
            end
            WB: begin
                regWriteNext = 1'b1;
                pcWriteNext  = 1'b1;
                doneNext     = 1'b1;
                stateNext    = FETCH;
            end
            HALT:    stateNext = HALT;
            default: stateNext = FETCH;
        endcase
    end

    // Datapath selects depend only on the latched class, so they stay put EXEC..end.
    always_comb begin
        regWriteCtrDec = 2'd0;
        regSelDec      = 2'd0;
        aluSelADec     = 1'b0;
        aluSelBDec     = 1'b0;
        aluCtrDec      = 4'd0;
        extCtrDec      = 2'd0;
        nPCSelDec      = 3'd0;
        case (classReg)
            C_ADDU: regSelDec = 2'd1;
            C_SUBU: begin regSelDec = 2'd1; aluCtrDec = 4'd1; end
            C_SLT:  begin regSelDec = 2'd1; aluCtrDec = 4'd4; end
            C_SLL:  begin regSelDec = 2'd1; aluCtrDec = 4'd5; aluSelADec = 1'b1; end
            C_JR:   nPCSelDec = 3'd3;
            C_ORI:  begin aluSelBDec = 1'b1; aluCtrDec = 4'd2; extCtrDec = 2'd0; end
            C_ADDIU, C_SW: begin aluSelBDec = 1'b1; extCtrDec = 2'd1; end
            C_LW:   begin aluSelBDec = 1'b1; extCtrDec = 2'd1; regWriteCtrDec = 2'd1; end
            C_LUI:  begin aluSelBDec = 1'b1; aluCtrDec = 4'd2; extCtrDec = 2'd2; end
            C_BEQ:  begin aluCtrDec = 4'd1; nPCSelDec = 3'd1; end
            C_BNE:  begin aluCtrDec = 4'd1; nPCSelDec = 3'd4; end
            C_J:    nPCSelDec = 3'd2;
            C_JAL:  begin nPCSelDec = 3'd2; regSelDec = 2'd2; regWriteCtrDec = 2'd2; end
            default: nPCSelDec = 3'd0;
        endcase
    end

    // Strobes are masked by Rst so a mid-instruction reset never commits a write.
    assign selActive   = !Rst && (stateReg == EXEC || stateReg == MEM || stateReg == WB);
    assign PCWrite     = pcWriteNext  && !Rst;
    assign IRWrite     = irWriteNext  && !Rst;
    assign RegWrite    = regWriteNext && !Rst;
    assign MemWrite    = memWriteNext && !Rst;
    assign InstrDone   = doneNext     && !Rst;
    assign Illegal     = illegalNext  && !Rst;
    assign RegWriteCtr = selActive ? regWriteCtrDec : 2'd0;
    assign RegSel      = selActive ? regSelDec      : 2'd0;
    assign ALUSelA     = selActive && aluSelADec;
    assign ALUSelB     = selActive && aluSelBDec;
    assign ALUCtr      = selActive ? aluCtrDec      : 4'd0;
    assign EXTCtr      = selActive ? extCtrDec      : 2'd0;
    assign nPCSel      = selActive ? nPCSelDec      : 3'd0;
    assign MemWriteCtr = 2'b00;
    assign MemOutCtr   = 3'b000;
    assign State       = stateReg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each scenario queues per-cycle expectations
// and compares them against both a NOP-on-illegal and a halt-on-illegal instance.
module tb_multicycle_ctrl;
    // Select-vector layout: {RegWriteCtr, RegSel, ALUSelA, ALUSelB, ALUCtr, EXTCtr, nPCSel, MemWriteCtr, MemOutCtr}
    localparam logic [19:0] M_ALL   = 20'hFFFFF;
    localparam logic [19:0] M_NOEXT = 20'hFFCFF;
    localparam logic [19:0] M_NOWB  = 20'h0FFFF;
    localparam logic [19:0] M_JUMP  = 20'h000FF;
    localparam logic [19:0] M_LINK  = 20'hF00FF;
    localparam logic [19:0] M_BR    = 20'h03CFF;
    localparam logic [19:0] M_JR    = 20'h07CFF;

    typedef struct packed {
        logic [8:0]  strb;
        logic [19:0] sel;
        logic [19:0] mask;
    } expT;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       RstH = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] func = 6'd0;

    logic       PCWrite, IRWrite, RegWrite, ALUSelA, ALUSelB, MemWrite, InstrDone, Illegal;
    logic [1:0] RegWriteCtr, RegSel, MemWriteCtr, EXTCtr;
    logic [3:0] ALUCtr;
    logic [2:0] MemOutCtr, nPCSel, State;

    logic       PCWriteH, IRWriteH, RegWriteH, ALUSelAH, ALUSelBH, MemWriteH, InstrDoneH, IllegalH;
    logic [1:0] RegWriteCtrH, RegSelH, MemWriteCtrH, EXTCtrH;
    logic [3:0] ALUCtrH;
    logic [2:0] MemOutCtrH, nPCSelH, StateH;

    logic [8:0]  obsStrb, obsStrbH;
    logic [19:0] obsSel;

    expT sb[$];
    int  errors = 0;
    int  checks = 0;
    int  txns = 0;

    always #5 Clk = ~Clk;

    multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut (
        .Clk(Clk), .Rst(Rst), .op(op), .func(func),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegWriteCtr(RegWriteCtr),
        .RegSel(RegSel), .ALUSelA(ALUSelA), .ALUSelB(ALUSelB), .ALUCtr(ALUCtr),
        .MemWrite(MemWrite), .MemWriteCtr(MemWriteCtr), .MemOutCtr(MemOutCtr), .EXTCtr(EXTCtr),
        .nPCSel(nPCSel), .State(State), .InstrDone(InstrDone), .Illegal(Illegal)
    );

    multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dutH (
        .Clk(Clk), .Rst(RstH), .op(op), .func(func),
        .PCWrite(PCWriteH), .IRWrite(IRWriteH), .RegWrite(RegWriteH), .RegWriteCtr(RegWriteCtrH),
        .RegSel(RegSelH), .ALUSelA(ALUSelAH), .ALUSelB(ALUSelBH), .ALUCtr(ALUCtrH),
        .MemWrite(MemWriteH), .MemWriteCtr(MemWriteCtrH), .MemOutCtr(MemOutCtrH), .EXTCtr(EXTCtrH),
        .nPCSel(nPCSelH), .State(StateH), .InstrDone(InstrDoneH), .Illegal(IllegalH)
    );

    assign obsStrb  = {State, PCWrite, IRWrite, RegWrite, MemWrite, InstrDone, Illegal};
    assign obsStrbH = {StateH, PCWriteH, IRWriteH, RegWriteH, MemWriteH, InstrDoneH, IllegalH};
    assign obsSel   = {RegWriteCtr, RegSel, ALUSelA, ALUSelB, ALUCtr, EXTCtr, nPCSel, MemWriteCtr, MemOutCtr};

    function automatic expT cyc(input logic [2:0] st, input logic pcw, input logic irw,
                                input logic rw, input logic mw, input logic done, input logic ill);
        expT e;
        e.strb = {st, pcw, irw, rw, mw, done, ill};
        e.sel  = '0;
        e.mask = '0;
        return e;
    endfunction

    function automatic expT withSel(input expT e, input logic [1:0] rwc, input logic [1:0] rsel,
                                    input logic a, input logic b, input logic [3:0] alu,
                                    input logic [1:0] ext, input logic [2:0] npc, input logic [19:0] m);
        e.sel  = {rwc, rsel, a, b, alu, ext, npc, 2'b00, 3'b000};
        e.mask = m;
        return e;
    endfunction

    // Expected cycle tables for the three common instruction shapes.
    task automatic pushRtype(input logic [3:0] alu, input logic a);
        sb.push_back(cyc(3'd0, 0, 1, 0, 0, 0, 0));
        sb.push_back(cyc(3'd1, 0, 0, 0, 0, 0, 0));
        sb.push_back(withSel(cyc(3'd2, 0, 0, 0, 0, 0, 0), 2'd0, 2'd1, a, 1'b0, alu, 2'd0, 3'd0, M_NOEXT));
        sb.push_back(withSel(cyc(3'd4, 1, 0, 1, 0, 1, 0), 2'd0, 2'd1, a, 1'b0, alu, 2'd0, 3'd0, M_NOEXT));
    endtask

    task automatic pushItype(input logic [3:0] alu, input logic [1:0] ext);
        sb.push_back(cyc(3'd0, 0, 1, 0, 0, 0, 0));
        sb.push_back(cyc(3'd1, 0, 0, 0, 0, 0, 0));
        sb.push_back(withSel(cyc(3'd2, 0, 0, 0, 0, 0, 0), 2'd0, 2'd0, 1'b0, 1'b1, alu, ext, 3'd0, M_ALL));
        sb.push_back(withSel(cyc(3'd4, 1, 0, 1, 0, 1, 0), 2'd0, 2'd0, 1'b0, 1'b1, alu, ext, 3'd0, M_ALL));
    endtask

    task automatic pushShort(input expT ex);
        sb.push_back(cyc(3'd0, 0, 1, 0, 0, 0, 0));
        sb.push_back(cyc(3'd1, 0, 0, 0, 0, 0, 0));
        sb.push_back(ex);
    endtask

    task automatic test_reset();
        expT e;
        op = 6'b000000; func = 6'b100001;
        sb.push_back(withSel(cyc(3'd0, 0, 0, 0, 0, 0, 0), 2'd0, 2'd0, 0, 0, 4'd0, 2'd0, 3'd0, M_ALL));
        sb.push_back(withSel(cyc(3'd0, 0, 0, 0, 0, 0, 0), 2'd0, 2'd0, 0, 0, 4'd0, 2'd0, 3'd0, M_ALL));
        pushRtype(4'd0, 1'b0);
        for (int k = 0; sb.size() > 0; k++) begin
            @(posedge Clk); #1;
            if (k == 2) Rst = 1'b0;
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obsStrb !== e.strb) begin
                errors++;
                $display("FAIL reset/addu cyc%0d state+strobes got=%b want=%b", k, obsStrb, e.strb);
            end
            if (e.mask != '0) begin
                checks++;
                if ((obsSel & e.mask) !== (e.sel & e.mask)) begin
                    errors++;
                    $display("FAIL reset/addu cyc%0d selects got=%h want=%h", k, obsSel & e.mask, e.sel & e.mask);
                end
            end
            if (e.strb[1]) begin txns++; $display("txn %0d reset/addu done at %0t", txns, $time); end
        end
    endtask

    task automatic test_reset_in_wb();
        expT e;
        op = 6'b000000; func = 6'b100001;
        pushRtype(4'd0, 1'b0);
        void'(sb.pop_back());
        sb.push_back(cyc(3'd4, 0, 0, 0, 0, 0, 0));
        sb.push_back(cyc(3'd0, 0, 0, 0, 0, 0, 0));
        sb.push_back(cyc(3'd0, 0, 0, 0, 0, 0, 0));
        pushRtype(4'd0, 1'b0);
        for (int k = 0; sb.size() > 0; k++) begin
            @(posedge Clk); #1;
            if (k == 3) Rst = 1'b1;
            if (k == 6) Rst = 1'b0;
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obsStrb !== e.strb) begin
                errors++;
                $display("FAIL reset_in_wb cyc%0d state+strobes got=%b want=%b", k, obsStrb, e.strb);
            end
            if (e.mask != '0) begin
                checks++;
                if ((obsSel & e.mask) !== (e.sel & e.mask)) begin
                    errors++;
                    $display("FAIL reset_in_wb cyc%0d selects got=%h want=%h", k, obsSel & e.mask, e.sel & e.mask);
                end
            end
            if (e.strb[1]) begin txns++; $display("txn %0d reset_in_wb done at %0t", txns, $time); end
        end
    endtask

    task automatic test_lw_sw();
        expT e;
        op = 6'b100011; func = 6'b000000;
        sb.push_back(cyc(3'd0, 0, 1, 0, 0, 0, 0));
        sb.push_back(cyc(3'd1, 0, 0, 0, 0, 0, 0));
        sb.push_back(withSel(cyc(3'd2, 0, 0, 0, 0, 0, 0), 2'd1, 2'd0, 0, 1, 4'd0, 2'd1, 3'd0, M_ALL));
        sb.push_back(withSel(cyc(3'd3, 0, 0, 0, 0, 0, 0), 2'd1, 2'd0, 0, 1, 4'd0, 2'd1, 3'd0, M_ALL));
        sb.push_back(withSel(cyc(3'd4, 1, 0, 1, 0, 1, 0), 2'd1, 2'd0, 0, 1, 4'd0, 2'd1, 3'd0, M_ALL));
        sb.push_back(cyc(3'd0, 0, 1, 0, 0, 0, 0));
        sb.push_back(cyc(3'd1, 0, 0, 0, 0, 0, 0));
        sb.push_back(withSel(cyc(3'd2, 0, 0, 0, 0, 0, 0), 2'd0, 2'd0, 0, 1, 4'd0, 2'd1, 3'd0, M_NOWB));
        sb.push_back(withSel(cyc(3'd3, 1, 0, 0, 1, 1, 0), 2'd0, 2'd0, 0, 1, 4'd0, 2'd1, 3'd0, M_NOWB));
        for (int k = 0; sb.size() > 0; k++) begin
            @(posedge Clk); #1;
            if (k == 5) op = 6'b101011;
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obsStrb !== e.strb) begin
                errors++;
                $display("FAIL lw_sw cyc%0d state+strobes got=%b want=%b", k, obsStrb, e.strb);
            end
            if (e.mask != '0) begin
                checks++;
                if ((obsSel & e.mask) !== (e.sel & e.mask)) begin
                    errors++;
                    $display("FAIL lw_sw cyc%0d selects got=%h want=%h", k, obsSel & e.mask, e.sel & e.mask);
                end
            end
            if (e.strb[1]) begin txns++; $display("txn %0d lw_sw done at %0t", txns, $time); end
        end
    endtask

    task automatic test_branch_jump();
        expT e;
        logic [5:0] opT [5];
        logic [5:0] fnT [5];
        opT = '{6'b000011, 6'b000010, 6'b000100, 6'b000101, 6'b000000};
        fnT = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000};
        pushShort(withSel(cyc(3'd2, 1, 0, 1, 0, 1, 0), 2'd2, 2'd2, 0, 0, 4'd0, 2'd0, 3'd2, M_LINK));
        pushShort(withSel(cyc(3'd2, 1, 0, 0, 0, 1, 0), 2'd0, 2'd0, 0, 0, 4'd0, 2'd0, 3'd2, M_JUMP));
        pushShort(withSel(cyc(3'd2, 1, 0, 0, 0, 1, 0), 2'd0, 2'd0, 0, 0, 4'd1, 2'd0, 3'd1, M_BR));
        pushShort(withSel(cyc(3'd2, 1, 0, 0, 0, 1, 0), 2'd0, 2'd0, 0, 0, 4'd1, 2'd0, 3'd4, M_BR));
        pushShort(withSel(cyc(3'd2, 1, 0, 0, 0, 1, 0), 2'd0, 2'd0, 0, 0, 4'd0, 2'd0, 3'd3, M_JR));
        for (int k = 0; sb.size() > 0; k++) begin
            @(posedge Clk); #1;
            if (k % 3 == 0) begin op = opT[k / 3]; func = fnT[k / 3]; end
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obsStrb !== e.strb) begin
                errors++;
                $display("FAIL branch_jump cyc%0d state+strobes got=%b want=%b", k, obsStrb, e.strb);
            end
            if (e.mask != '0) begin
                checks++;
                if ((obsSel & e.mask) !== (e.sel & e.mask)) begin
                    errors++;
                    $display("FAIL branch_jump cyc%0d selects got=%h want=%h", k, obsSel & e.mask, e.sel & e.mask);
                end
            end
            if (e.strb[1]) begin txns++; $display("txn %0d branch_jump op=%b done at %0t", txns, op, $time); end
        end
    endtask

    task automatic test_back_to_back();
        expT e;
        logic [5:0] opT [6];
        logic [5:0] fnT [6];
        opT = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001001, 6'b001111};
        fnT = '{6'b100011, 6'b101010, 6'b000000, 6'b101010, 6'b100011, 6'b001000};
        pushRtype(4'd1, 1'b0);
        pushRtype(4'd4, 1'b0);
        pushRtype(4'd5, 1'b1);
        pushItype(4'd2, 2'd0);
        pushItype(4'd0, 2'd1);
        pushItype(4'd2, 2'd2);
        for (int k = 0; sb.size() > 0; k++) begin
            @(posedge Clk); #1;
            if (k % 4 == 0) begin op = opT[k / 4]; func = fnT[k / 4]; end
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obsStrb !== e.strb) begin
                errors++;
                $display("FAIL back_to_back cyc%0d state+strobes got=%b want=%b", k, obsStrb, e.strb);
            end
            if (e.mask != '0) begin
                checks++;
                if ((obsSel & e.mask) !== (e.sel & e.mask)) begin
                    errors++;
                    $display("FAIL back_to_back cyc%0d selects got=%h want=%h", k, obsSel & e.mask, e.sel & e.mask);
                end
            end
            if (e.strb[1]) begin txns++; $display("txn %0d back_to_back op=%b func=%b done at %0t", txns, op, func, $time); end
        end
    endtask

    task automatic test_illegal_nop();
        expT e;
        sb.push_back(cyc(3'd0, 0, 1, 0, 0, 0, 0));
        sb.push_back(cyc(3'd1, 0, 0, 0, 0, 0, 1));
        sb.push_back(withSel(cyc(3'd2, 1, 0, 0, 0, 1, 0), 2'd0, 2'd0, 0, 0, 4'd0, 2'd0, 3'd0, M_JUMP));
        sb.push_back(cyc(3'd0, 0, 1, 0, 0, 0, 0));
        sb.push_back(cyc(3'd1, 0, 0, 0, 0, 0, 1));
        sb.push_back(withSel(cyc(3'd2, 1, 0, 0, 0, 1, 0), 2'd0, 2'd0, 0, 0, 4'd0, 2'd0, 3'd0, M_JUMP));
        pushRtype(4'd0, 1'b0);
        for (int k = 0; sb.size() > 0; k++) begin
            @(posedge Clk); #1;
            if (k == 0) begin op = 6'b111111; func = 6'b100001; end
            if (k == 3) begin op = 6'b000000; func = 6'b111111; end
            if (k == 6) func = 6'b100001;
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obsStrb !== e.strb) begin
                errors++;
                $display("FAIL illegal_nop cyc%0d state+strobes got=%b want=%b", k, obsStrb, e.strb);
            end
            if (e.mask != '0) begin
                checks++;
                if ((obsSel & e.mask) !== (e.sel & e.mask)) begin
                    errors++;
                    $display("FAIL illegal_nop cyc%0d selects got=%h want=%h", k, obsSel & e.mask, e.sel & e.mask);
                end
            end
            if (e.strb[1]) begin txns++; $display("txn %0d illegal_nop done at %0t", txns, $time); end
        end
    endtask

    task automatic test_halt();
        expT e;
        op = 6'b111111; func = 6'b000000;
        sb.push_back(cyc(3'd0, 0, 1, 0, 0, 0, 0));
        sb.push_back(cyc(3'd1, 0, 0, 0, 0, 0, 1));
        repeat (5) sb.push_back(cyc(3'd7, 0, 0, 0, 0, 0, 0));
        sb.push_back(cyc(3'd0, 0, 0, 0, 0, 0, 0));
        sb.push_back(cyc(3'd0, 0, 1, 0, 0, 0, 0));
        sb.push_back(cyc(3'd1, 0, 0, 0, 0, 0, 1));
        sb.push_back(cyc(3'd7, 0, 0, 0, 0, 0, 0));
        for (int k = 0; sb.size() > 0; k++) begin
            @(posedge Clk); #1;
            if (k == 0) RstH = 1'b0;
            if (k == 6) RstH = 1'b1;
            if (k == 8) RstH = 1'b0;
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obsStrbH !== e.strb) begin
                errors++;
                $display("FAIL halt cyc%0d state+strobes got=%b want=%b", k, obsStrbH, e.strb);
            end
        end
        txns++;
        $display("txn %0d halt sequence checked at %0t", txns, $time);
    endtask

    initial begin
        test_reset();
        test_reset_in_wb();
        test_lw_sw();
        test_branch_jump();
        test_back_to_back();
        test_illegal_nop();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
